// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 RGB565 byte stream to RGB332 frame-buffer writes
module ov7670_capture #(
    parameter int WIDTH  = 176,
    parameter int HEIGHT = 144
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] CAM_DATA,
    input  logic       CAM_HREF,
    input  logic       CAM_VSYNC,
    output logic [7:0] PIXEL_OUT,
    output logic [9:0] X_ADDR,
    output logic [9:0] Y_ADDR,
    output logic       W_EN,
    output logic       FRAME_DONE,
    output logic       LINE_ERR
);
    localparam logic [9:0] W_LIM = 10'(WIDTH);
    localparam logic [9:0] H_LIM = 10'(HEIGHT);
    localparam logic [9:0] X_MAX = 10'h3FF;

    typedef enum logic {SYNC, ACTIVE} state_t;

    state_t     state;
    logic       href_d;
    logic       vsync_d;
    logic       phase;
    logic [5:0] byte1;
    logic [9:0] xcount;
    logic [9:0] ycount;

    logic       vs_fall;
    logic       vs_rise;
    logic       hr_fall;
    logic [7:0] pixel;

    assign vs_fall = vsync_d & ~CAM_VSYNC;
    assign vs_rise = ~vsync_d & CAM_VSYNC;
    assign hr_fall = href_d & ~CAM_HREF;
    // Only R[7:5] and G[2:0] of the first byte survive the 332 packing.
    assign pixel   = {byte1, CAM_DATA[4:3]};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= SYNC;
            href_d     <= 1'b0;
            vsync_d    <= 1'b0;
            phase      <= 1'b0;
            byte1      <= '0;
            xcount     <= '0;
            ycount     <= '0;
            PIXEL_OUT  <= '0;
            X_ADDR     <= '0;
            Y_ADDR     <= '0;
            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;
            LINE_ERR   <= 1'b0;
        end else begin
            href_d     <= CAM_HREF;
            vsync_d    <= CAM_VSYNC;
            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;
            case (state)
                SYNC: begin
                    phase <= 1'b0;
                    if (vs_fall) begin
                        state    <= ACTIVE;
                        xcount   <= '0;
                        ycount   <= '0;
                        LINE_ERR <= 1'b0;
                    end
                end
                ACTIVE: begin
                    // Frame end wins over any concurrent line activity.
                    if (vs_rise) begin
                        FRAME_DONE <= 1'b1;
                        state      <= SYNC;
                        phase      <= 1'b0;
                        xcount     <= '0;
                    end else if (CAM_HREF) begin
                        if (!phase) begin
                            byte1 <= {CAM_DATA[7:5], CAM_DATA[2:0]};
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (xcount < W_LIM && ycount < H_LIM) begin
                                W_EN      <= 1'b1;
                                PIXEL_OUT <= pixel;
                                X_ADDR    <= xcount;
                                Y_ADDR    <= ycount;
                            end
                            if (xcount != X_MAX)
                                xcount <= xcount + 10'd1;
                        end
                    end else if (hr_fall) begin
                        if (phase || xcount > W_LIM)
                            LINE_ERR <= 1'b1;
                        if (xcount != 10'd0 && ycount < H_LIM)
                            ycount <= ycount + 10'd1;
                        xcount <= '0;
                        phase  <= 1'b0;
                    end else begin
                        phase <= 1'b0;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - self-checking bench for ov7670_capture
module tb_ov7670_capture;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       href = 1'b0;
    logic       vsync = 1'b0;
    logic [7:0] pixel_out;
    logic [9:0] x_addr;
    logic [9:0] y_addr;
    logic       w_en;
    logic       frame_done;
    logic       line_err;

    ov7670_capture dut (
        .CLK(clk), .RESET(rst), .CAM_DATA(data), .CAM_HREF(href), .CAM_VSYNC(vsync),
        .PIXEL_OUT(pixel_out), .X_ADDR(x_addr), .Y_ADDR(y_addr), .W_EN(w_en),
        .FRAME_DONE(frame_done), .LINE_ERR(line_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        int         x;
        int         y;
        logic [7:0] p;
    } wr_t;

    wr_t wq[$];
    int  fd_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  nw = 0;
    int  nfd = 0;
    bit  active = 0;
    int  mline = 0;
    bit  exp_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // RGB565 -> RGB332 by truncating each channel to its top bits.
    function automatic logic [7:0] pack(input logic [7:0] hi, input logic [7:0] lo);
        int r5, g6, b5;
        r5 = int'(hi) >> 3;
        g6 = ((int'(hi) & 7) << 3) | (int'(lo) >> 5);
        b5 = int'(lo) & 31;
        return 8'(((r5 >> 2) << 5) | ((g6 >> 3) << 2) | (b5 >> 3));
    endfunction

    always @(negedge clk) begin
        bit ew, ef;
        ew = (wq.size() > 0) && (wq[0].c == cyc);
        ef = (fd_q.size() > 0) && (fd_q[0] == cyc);
        check("w_en", 32'(w_en), 32'(ew));
        check("frame_done", 32'(frame_done), 32'(ef));
        if (w_en) nw++;
        if (frame_done) nfd++;
        if (ew) begin
            check("wr_x", 32'(x_addr), wq[0].x);
            check("wr_y", 32'(y_addr), wq[0].y);
            check("wr_pixel", 32'(pixel_out), 32'(wq[0].p));
            void'(wq.pop_front());
        end
        if (ef) void'(fd_q.pop_front());
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // mode 0: normal line end; 1: leave HREF high (caller aborts); 2: VSYNC rises with HREF high
    task automatic send_line(input int n, input logic [7:0] b1, input logic [7:0] b2, input int mode);
        int x = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            href = 1'b1;
            data = (i % 2 == 0) ? b1 : b2;
            if (i % 2 == 1) begin
                if (active && x < 176 && mline < 144)
                    wq.push_back('{cyc + 1, x, mline, pack(b1, b2)});
                x++;
            end
        end
        if (mode == 0) begin
            @(posedge clk); #1;
            href = 1'b0;
            data = 8'h00;
            if (active) begin
                if ((n % 2) == 1 || x > 176) exp_err = 1;
                if (x > 0 && mline < 144) mline++;
            end
            idle(3);
        end else if (mode == 2) begin
            @(posedge clk); #1;
            data  = b2;
            vsync = 1'b1;
            if (active) begin
                fd_q.push_back(cyc + 1);
                active = 0;
            end
            @(posedge clk); #1;
            href = 1'b0;
            idle(3);
        end
    endtask

    task automatic frame_start;
        @(posedge clk); #1;
        vsync = 1'b1;
        idle(2);
        vsync = 1'b0;
        if (!active) begin
            active  = 1;
            mline   = 0;
            exp_err = 0;
        end
        idle(2);
    endtask

    task automatic frame_end;
        @(posedge clk); #1;
        vsync = 1'b1;
        if (active) begin
            fd_q.push_back(cyc + 1);
            active = 0;
        end
        idle(3);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        wq.delete();
        fd_q.delete();
        active  = 0;
        exp_err = 0;
        mline   = 0;
        href    = 1'b0;
        #1;
        check("rst_pixel", 32'(pixel_out), 32'h0);
        check("rst_x", 32'(x_addr), 32'h0);
        check("rst_y", 32'(y_addr), 32'h0);
        check("rst_wen", 32'(w_en), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        check("rst_err", 32'(line_err), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int w0;
        check("model_pack_e3", 32'(pack(8'hF8, 8'h1F)), 32'hE3);
        check("model_pack_1c", 32'(pack(8'h07, 8'hE0)), 32'h1C);
        check("model_pack_03", 32'(pack(8'h00, 8'h18)), 32'h03);
        do_reset();

        // HREF activity before any VSYNC fall
        send_line(20, 8'hF8, 8'h1F, 0);
        check("presync_writes", nw, 0);
        check("presync_fd", nfd, 0);

        // full frame plus one surplus line beyond HEIGHT
        frame_start();
        w0 = nw;
        for (int l = 0; l < 145; l++) send_line(352, 8'hF8, 8'h1F, 0);
        frame_end();
        check("frame1_writes", nw - w0, 25344);
        check("frame1_fd", nfd, 1);
        check("frame1_err", 32'(line_err), 32'(exp_err));
        check("frame1_err_lit", 32'(line_err), 32'h0);
        check("frame1_last_x", 32'(x_addr), 175);
        check("frame1_last_y", 32'(y_addr), 143);
        check("frame1_pixel", 32'(pixel_out), 32'hE3);

        // packing and long line
        frame_start();
        send_line(2, 8'h07, 8'hE0, 0);
        check("pack_1c", 32'(pixel_out), 32'h1C);
        send_line(2, 8'h00, 8'h18, 0);
        check("pack_03", 32'(pixel_out), 32'h03);
        check("pack_03_y", 32'(y_addr), 1);
        check("short_err", 32'(line_err), 32'h0);
        send_line(400, 8'h5A, 8'hC3, 0);
        check("long_err", 32'(line_err), 32'h1);
        check("long_last_x", 32'(x_addr), 175);
        frame_end();
        check("long_err_sticky", 32'(line_err), 32'h1);

        // odd line, following line, frame end while HREF high
        frame_start();
        check("err_cleared", 32'(line_err), 32'h0);
        send_line(351, 8'h12, 8'h34, 0);
        check("odd_err", 32'(line_err), 32'h1);
        check("odd_last_x", 32'(x_addr), 174);
        send_line(352, 8'h9C, 8'h6B, 0);
        check("after_odd_y", 32'(y_addr), 1);
        send_line(5, 8'hAB, 8'hCD, 2);
        check("vsabort_err", 32'(line_err), 32'h1);
        check("vsabort_fd", nfd, 3);

        // reset in the middle of line 50
        frame_start();
        for (int l = 0; l < 50; l++) send_line(4, 8'h55, 8'hAA, 0);
        send_line(3, 8'h55, 8'hAA, 1);
        check("abort_y", 32'(y_addr), 50);
        do_reset();

        frame_start();
        send_line(8, 8'hF8, 8'h1F, 0);
        check("restart_x", 32'(x_addr), 3);
        check("restart_y", 32'(y_addr), 0);
        frame_end();
        check("total_fd", nfd, 4);
        check("queues_drained", wq.size() + fd_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
